// File: rtl/score_button_conditioner.sv
// score_button_conditioner
// Synchronises and debounces seven raw board inputs and turns them into
// clean controls for the scoreboard. Point buttons become arbitrated
// single-cycle pulses. Reset buttons become independent single-cycle pulses.
// The slide switches pass through as debounced levels.
module score_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_one,
    input  logic btn_two,
    input  logic btn_three,
    input  logic btn_reset_points,
    input  logic btn_reset_score,
    input  logic sw_team,
    input  logic sw_pause,
    output logic one_point,
    output logic two_point,
    output logic three_point,
    output logic reset_points,
    output logic reset_score,
    output logic team,
    output logic pause
);

    localparam int NCH = 7;

    // Channel indices into the packed channel vectors.
    localparam int CH_ONE       = 0;
    localparam int CH_TWO       = 1;
    localparam int CH_THREE     = 2;
    localparam int CH_RST_PTS   = 3;
    localparam int CH_RST_SCORE = 4;
    localparam int CH_TEAM      = 5;
    localparam int CH_PAUSE     = 6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]            raw_in;
    logic [NCH-1:0]            s1_q, s1_d;
    logic [NCH-1:0]            s2_q, s2_d;
    logic [NCH-1:0]            db_q, db_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]            rise;

    logic one_point_q, one_point_d;
    logic two_point_q, two_point_d;
    logic three_point_q, three_point_d;
    logic reset_points_q, reset_points_d;
    logic reset_score_q, reset_score_d;

    assign raw_in = {sw_pause, sw_team, btn_reset_score, btn_reset_points,
                     btn_three, btn_two, btn_one};

    // Two-flop synchroniser chain for every raw input.
    always_comb begin
        s1_d = raw_in;
        s2_d = s1_q;
    end

    // Debounce: accept a new level only after it has been stable long enough.
    // The rise flag is the next-state edge, so the pulse leaves on the same
    // edge that updates the debounced state.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise = db_d & ~db_q;
    end

    // Point arbitration: three beats two beats one. A point is also blocked
    // while another point button is still held down.
    always_comb begin
        three_point_d  = rise[CH_THREE] & ~db_q[CH_TWO] & ~db_q[CH_ONE];
        two_point_d    = rise[CH_TWO] & ~rise[CH_THREE]
                         & ~db_q[CH_THREE] & ~db_q[CH_ONE];
        one_point_d    = rise[CH_ONE] & ~rise[CH_THREE] & ~rise[CH_TWO]
                         & ~db_q[CH_THREE] & ~db_q[CH_TWO];
        reset_points_d = rise[CH_RST_PTS];
        reset_score_d  = rise[CH_RST_SCORE];
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q           <= '0;
            s2_q           <= '0;
            db_q           <= '0;
            cnt_q          <= '0;
            one_point_q    <= 1'b0;
            two_point_q    <= 1'b0;
            three_point_q  <= 1'b0;
            reset_points_q <= 1'b0;
            reset_score_q  <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            db_q           <= db_d;
            cnt_q          <= cnt_d;
            one_point_q    <= one_point_d;
            two_point_q    <= two_point_d;
            three_point_q  <= three_point_d;
            reset_points_q <= reset_points_d;
            reset_score_q  <= reset_score_d;
        end
    end

    assign one_point    = one_point_q;
    assign two_point    = two_point_q;
    assign three_point  = three_point_q;
    assign reset_points = reset_points_q;
    assign reset_score  = reset_score_q;
    assign team         = db_q[CH_TEAM];
    assign pause        = db_q[CH_PAUSE];

endmodule

// File: tb/tb_score_button_conditioner.sv
// tb_score_button_conditioner
// Directed stimulus with a pulse scoreboard: every expected pulse is queued
// with the cycle it must appear in, and a monitor pops it when the DUT pulses.
module tb_score_button_conditioner;

    localparam int DEB = 4;
    localparam int CW  = 3;
    // A raw change applied at a negedge with cycle count c pulses at c+DEB+2.
    localparam int LAT = DEB + 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic btn_one = 1'b0, btn_two = 1'b0, btn_three = 1'b0;
    logic btn_reset_points = 1'b0, btn_reset_score = 1'b0;
    logic sw_team = 1'b0, sw_pause = 1'b0;
    logic one_point, two_point, three_point, reset_points, reset_score, team, pause;

    logic [4:0] pulses;
    logic [6:0] outs;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } exp_t;

    exp_t sb[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    score_button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_one(btn_one),
        .btn_two(btn_two),
        .btn_three(btn_three),
        .btn_reset_points(btn_reset_points),
        .btn_reset_score(btn_reset_score),
        .sw_team(sw_team),
        .sw_pause(sw_pause),
        .one_point(one_point),
        .two_point(two_point),
        .three_point(three_point),
        .reset_points(reset_points),
        .reset_score(reset_score),
        .team(team),
        .pause(pause)
    );

    assign pulses = {reset_score, reset_points, three_point, two_point, one_point};
    assign outs   = {pause, team, pulses};

    // Free-running clock.
    always #5 clock = ~clock;

    // Count rising edges so expectations can name an exact cycle.
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: any pulse must match the head of the scoreboard exactly.
    always @(negedge clock) begin
        exp_t e;
        if (|pulses === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse cyc=%0d got=%b expected none", cyc, pulses);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.vec !== pulses) begin
                    errors++;
                    $display("[TB] FAIL pulse cyc=%0d got=%b expected=%b at cyc=%0d",
                             cyc, pulses, e.vec, e.cyc);
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Raw bits: {sw_pause, sw_team, rst_score, rst_points, three, two, one}.
    task automatic applyStimulus(input logic [6:0] raw);
        {sw_pause, sw_team, btn_reset_score, btn_reset_points,
         btn_three, btn_two, btn_one} = raw;
    endtask

    // Pulse vector: {reset_score, reset_points, three, two, one}.
    task automatic expectPulse(input logic [4:0] vec);
        exp_t e;
        e.cyc = cyc + LAT;
        e.vec = vec;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [6:0] expv);
        checks++;
        if (outs !== expv) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%b expected=%b", name, cyc, outs, expv);
        end
    endtask

    initial begin
        logic [4:0] bpat;
        bpat = 5'b01101;

        // Reset with every raw input high.
        applyStimulus(7'h7F);
        reset = 1'b0;
        waitCycles(2);
        checkOutput("reset_state", 7'b0);
        reset = 1'b1;
        expectPulse(5'b11100);
        waitCycles(LAT - 1);
        checkOutput("before_first_debounce", 7'b0);
        waitCycles(1);
        checkOutput("after_reset_release", 7'b1111100);
        waitCycles(15);
        checkOutput("all_held_no_pulse", 7'b1100000);
        applyStimulus(7'b0);
        waitCycles(10);
        checkOutput("all_released", 7'b0);

        // Team switch level latency.
        applyStimulus(7'b0100000);
        waitCycles(LAT - 1);
        checkOutput("team_before", 7'b0);
        waitCycles(1);
        checkOutput("team_after", 7'b0100000);
        applyStimulus(7'b0);
        waitCycles(10);
        checkOutput("team_released", 7'b0);

        // Clean press held for 20 cycles.
        $display("[TB] clean press");
        applyStimulus(7'b0000001);
        expectPulse(5'b00001);
        waitCycles(20);
        applyStimulus(7'b0);
        waitCycles(12);

        // Bouncing press on btn_two.
        $display("[TB] bounce");
        for (int i = 0; i < 5; i++) begin
            applyStimulus({5'b0, bpat[i], 1'b0});
            waitCycles(1);
        end
        applyStimulus(7'b0000010);
        expectPulse(5'b00010);
        waitCycles(15);
        applyStimulus(7'b0);
        waitCycles(10);

        // Simultaneous presses, then a press blocked by a held button.
        $display("[TB] simultaneous and held");
        applyStimulus(7'b0000111);
        expectPulse(5'b00100);
        waitCycles(10);
        applyStimulus(7'b0000100);
        waitCycles(10);
        applyStimulus(7'b0000101);
        waitCycles(10);
        applyStimulus(7'b0);
        waitCycles(10);
        applyStimulus(7'b0000001);
        expectPulse(5'b00001);
        waitCycles(10);
        applyStimulus(7'b0);
        waitCycles(10);

        // Reset buttons alongside points, and repeated presses.
        $display("[TB] reset buttons");
        applyStimulus(7'b0001010);
        expectPulse(5'b01010);
        waitCycles(10);
        applyStimulus(7'b0);
        waitCycles(10);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(7'b0010000);
            expectPulse(5'b10000);
            waitCycles(8);
            applyStimulus(7'b0);
            waitCycles(8);
        end

        // Reset in the middle of a debounce count.
        $display("[TB] mid-count reset");
        applyStimulus(7'b0000100);
        waitCycles(3);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("mid_reset_state", 7'b0);
        reset = 1'b1;
        expectPulse(5'b00100);
        waitCycles(10);
        applyStimulus(7'b0);
        waitCycles(10);

        // Every queued pulse must have been seen.
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_pulses got=%0d outstanding expected=0 (next at cyc=%0d vec=%b)",
                     sb.size(), sb[0].cyc, sb[0].vec);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
